flash_write_guard: RTL and testbench

FLASH_WRITE_GUARD -- requirements
Module: flash_write_guard

---
 rtl/flash_guard_pkg.sv | 37 +++
 rtl/flash_guard_timer.sv | 27 ++
 rtl/flash_write_guard.sv | 138 +++++++++++++
 tb/tb_flash_write_guard.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/flash_guard_pkg.sv
// Shared state encoding, unlock-command constants and widths for the flash write guard.
package flash_guard_pkg;

  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CMD_ADDR_W = 12;
  localparam int unsigned TMR_W      = 16;
  localparam int unsigned STATE_W    = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 4'd0,
    ST_U1   = 4'd1,
    ST_U2   = 4'd2,
    ST_PROG = 4'd3,
    ST_E1   = 4'd4,
    ST_E2   = 4'd5,
    ST_E3   = 4'd6,
    ST_BUSY = 4'd7
  } state_e;

  localparam logic [CMD_ADDR_W-1:0] ADDR_555 = 12'h555;
  localparam logic [CMD_ADDR_W-1:0] ADDR_2AA = 12'h2AA;

  localparam logic [DATA_W-1:0] DATA_AA = 8'hAA;
  localparam logic [DATA_W-1:0] DATA_55 = 8'h55;
  localparam logic [DATA_W-1:0] DATA_A0 = 8'hA0;
  localparam logic [DATA_W-1:0] DATA_80 = 8'h80;
  localparam logic [DATA_W-1:0] DATA_30 = 8'h30;
  localparam logic [DATA_W-1:0] DATA_10 = 8'h10;
  localparam logic [DATA_W-1:0] DATA_F0 = 8'hF0;

  // States in which the inter-write idle timeout runs.
  function automatic logic in_sequence(input state_e s);
    return (s >= ST_U1) && (s <= ST_E3);
  endfunction

endpackage

// File: rtl/flash_guard_timer.sv
// Loadable down-counter shared by the BUSY duration and the mid-sequence idle timeout.
module flash_guard_timer
  import flash_guard_pkg::*;
(
  input  logic             m2,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - TMR_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/flash_write_guard.sv
// Gates CPU writes to flash so only well-formed program/erase command sequences get through.
// Optional macro FLASH_GUARD_STATS_EN enables the saturating blocked-write counter.
module flash_write_guard
  import flash_guard_pkg::*;
#(
  parameter int unsigned PROG_BUSY_CYCLES  = 16,
  parameter int unsigned ERASE_BUSY_CYCLES = 4095,
  parameter int unsigned SEQ_TIMEOUT       = 64
) (
  input  logic               m2,
  input  logic               reset,
  input  logic               romsel,
  input  logic               cpu_rw_in,
  input  logic [ADDR_W-1:0]  cpu_addr_in,
  input  logic [DATA_W-1:0]  cpu_data_in,
  input  logic               prg_write_enabled,
  output logic               flash_we_allow,
  output logic               busy,
  output logic [STATE_W-1:0] seq_state,
  output logic               reject_pulse,
  output logic [7:0]         reject_count
);

  state_e                state;
  state_e                state_next;
  logic                  rom_write;
  logic                  match;
  logic                  abort_cmd;
  logic                  tmr_load;
  logic                  tmr_dec;
  logic                  tmr_zero;
  logic [TMR_W-1:0]      tmr_val;
  logic [CMD_ADDR_W-1:0] a;
  logic [DATA_W-1:0]     d;

  // Upper address bits select the flash bank and play no part in the unlock decode.
  logic unused_addr;
  assign unused_addr = &{1'b0, cpu_addr_in[ADDR_W-1:CMD_ADDR_W]};

  assign a         = cpu_addr_in[CMD_ADDR_W-1:0];
  assign d         = cpu_data_in;
  assign rom_write = !romsel && !cpu_rw_in;
  assign abort_cmd = (d == DATA_F0);

  always_comb begin
    match = 1'b0;
    unique case (state)
      ST_IDLE: match = (a == ADDR_555) && (d == DATA_AA);
      ST_U1:   match = (a == ADDR_2AA) && (d == DATA_55);
      ST_U2:   match = (a == ADDR_555) && ((d == DATA_A0) || (d == DATA_80));
      ST_PROG: match = 1'b1;
      ST_E1:   match = (a == ADDR_555) && (d == DATA_AA);
      ST_E2:   match = (a == ADDR_2AA) && (d == DATA_55);
      ST_E3:   match = (d == DATA_30) || ((a == ADDR_555) && (d == DATA_10));
      ST_BUSY: match = 1'b0;
      default: match = 1'b0;
    endcase
  end

  assign flash_we_allow = !reset && prg_write_enabled && rom_write && (match || abort_cmd);
  assign reject_pulse   = !reset && prg_write_enabled && rom_write && !flash_we_allow;

  // Next state and timer control; F0h always returns to IDLE, even mid-BUSY.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    tmr_val    = '0;
    if (!prg_write_enabled) begin
      state_next = ST_IDLE;
    end else if (rom_write && abort_cmd) begin
      state_next = ST_IDLE;
    end else if (state == ST_BUSY) begin
      if (tmr_zero) state_next = ST_IDLE;
      else          tmr_dec    = 1'b1;
    end else if (rom_write) begin
      if (!match) begin
        state_next = ST_IDLE;
      end else begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(SEQ_TIMEOUT - 1);
        unique case (state)
          ST_IDLE: state_next = ST_U1;
          ST_U1:   state_next = ST_U2;
          ST_U2:   state_next = (d == DATA_A0) ? ST_PROG : ST_E1;
          ST_E1:   state_next = ST_E2;
          ST_E2:   state_next = ST_E3;
          ST_PROG: begin
            state_next = ST_BUSY;
            tmr_val    = TMR_W'(PROG_BUSY_CYCLES - 1);
          end
          ST_E3: begin
            state_next = ST_BUSY;
            tmr_val    = TMR_W'(ERASE_BUSY_CYCLES - 1);
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end else if (in_sequence(state)) begin
      if (tmr_zero) state_next = ST_IDLE;
      else          tmr_dec    = 1'b1;
    end
  end

  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_BUSY);
    end
  end

  assign seq_state = state;

  flash_guard_timer u_timer (
    .m2       (m2),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

`ifdef FLASH_GUARD_STATS_EN
  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      reject_count <= '0;
    end else if (reject_pulse && (reject_count != 8'hFF)) begin
      reject_count <= reject_count + 8'd1;
    end
  end
`else
  assign reject_count = '0;
`endif

endmodule

// File: tb/tb_flash_write_guard.sv
// Scoreboard bench for flash_write_guard: each bus cycle queues its expected outcome.
module tb_flash_write_guard;

`ifdef FLASH_GUARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [3:0] S_IDLE = 4'd0, S_U1 = 4'd1, S_U2 = 4'd2, S_PROG = 4'd3;
  localparam logic [3:0] S_E1 = 4'd4, S_E2 = 4'd5, S_E3 = 4'd6, S_BUSY = 4'd7;

  logic        m2 = 1'b0;
  logic        reset;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        prg_write_enabled;
  logic        flash_we_allow;
  logic        busy;
  logic [3:0]  seq_state;
  logic        reject_pulse;
  logic [7:0]  reject_count;

  typedef struct {
    string      tag;
    logic       allow;
    logic       rej;
    logic [3:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_rejects = 0;

  flash_write_guard dut (
    .m2                (m2),
    .reset             (reset),
    .romsel            (romsel),
    .cpu_rw_in         (cpu_rw_in),
    .cpu_addr_in       (cpu_addr_in),
    .cpu_data_in       (cpu_data_in),
    .prg_write_enabled (prg_write_enabled),
    .flash_we_allow    (flash_we_allow),
    .busy              (busy),
    .seq_state         (seq_state),
    .reject_pulse      (reject_pulse),
    .reject_count      (reject_count)
  );

  always #5 m2 = ~m2;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_count();
    return STATS ? 8'(exp_rejects) : 8'h00;
  endfunction

  // One bus cycle: drive at negedge, check comb outputs mid-cycle, state after the edge.
  task automatic cyc(input logic wr, input logic [14:0] addr, input logic [7:0] data,
                     input logic allow, input logic [3:0] st, input string tag);
    exp_t e;
    @(negedge m2);
    romsel      = 1'b0;
    cpu_rw_in   = !wr;
    cpu_addr_in = addr;
    cpu_data_in = data;
    sb.push_back('{tag, allow, wr && prg_write_enabled && !allow, st});
    #2;
    e = sb.pop_front();
    check({e.tag, "_allow"}, 16'(flash_we_allow), 16'(e.allow));
    check({e.tag, "_reject"}, 16'(reject_pulse), 16'(e.rej));
    if (e.rej && exp_rejects < 255) exp_rejects++;
    @(posedge m2);
    #1;
    check({e.tag, "_state"}, 16'(seq_state), 16'(e.st));
    check({e.tag, "_busy"}, 16'(busy), 16'(e.st == S_BUSY));
    check({e.tag, "_rcount"}, 16'(reject_count), 16'(exp_count()));
  endtask

  task automatic rd(input logic [3:0] st, input string tag);
    cyc(1'b0, 15'h0000, 8'h00, 1'b0, st, tag);
  endtask

  task automatic wr(input logic [14:0] addr, input logic [7:0] data,
                    input logic allow, input logic [3:0] st, input string tag);
    cyc(1'b1, addr, data, allow, st, tag);
  endtask

  task automatic program_to_busy(input string tag);
    wr(15'h0555, 8'hAA, 1'b1, S_U1, {tag, "_c1"});
    wr(15'h02AA, 8'h55, 1'b1, S_U2, {tag, "_c2"});
    wr(15'h0555, 8'hA0, 1'b1, S_PROG, {tag, "_c3"});
    wr(15'h1234, 8'h5C, 1'b1, S_BUSY, {tag, "_data"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    romsel = 1'b1;
    cpu_rw_in = 1'b1;
    cpu_addr_in = '0;
    cpu_data_in = '0;
    prg_write_enabled = 1'b1;
    repeat (2) @(posedge m2);
    #1;
    check("reset_state", 16'(seq_state), 16'(S_IDLE));
    check("reset_busy", 16'(busy), 16'h0);
    check("reset_allow", 16'(flash_we_allow), 16'h0);
    check("reset_rcount", 16'(reject_count), 16'h0);
    @(negedge m2);
    reset = 1'b0;

    // Program: four allowed writes, then busy for 16 cycles in total.
    program_to_busy("prog");
    for (int i = 0; i < 15; i++) rd(S_BUSY, "prog_busy");
    rd(S_IDLE, "prog_done");

    // Stray write in IDLE.
    wr(15'h0100, 8'h77, 1'b0, S_IDLE, "stray");

    // Wrong second unlock write aborts the sequence.
    wr(15'h0555, 8'hAA, 1'b1, S_U1, "bad_c1");
    wr(15'h0555, 8'h55, 1'b0, S_IDLE, "bad_c2");

    // Sector erase: six allowed writes, a blocked write during busy, 4095 busy cycles.
    wr(15'h0555, 8'hAA, 1'b1, S_U1, "er_c1");
    wr(15'h02AA, 8'h55, 1'b1, S_U2, "er_c2");
    wr(15'h0555, 8'h80, 1'b1, S_E1, "er_c3");
    wr(15'h0555, 8'hAA, 1'b1, S_E2, "er_c4");
    wr(15'h02AA, 8'h55, 1'b1, S_E3, "er_c5");
    wr(15'h0000, 8'h30, 1'b1, S_BUSY, "er_c6");
    wr(15'h0555, 8'hAA, 1'b0, S_BUSY, "er_blocked");
    for (int i = 0; i < 4093; i++) rd(S_BUSY, "er_busy");
    rd(S_IDLE, "er_done");

    // Abort with F0h during busy.
    program_to_busy("abort");
    wr(15'h0000, 8'hF0, 1'b1, S_IDLE, "abort_f0");

    // Idle timeout: 63 reads stay in U1, the 64th returns to IDLE.
    wr(15'h0555, 8'hAA, 1'b1, S_U1, "to_c1");
    for (int i = 0; i < 63; i++) rd(S_U1, "to_wait");
    rd(S_IDLE, "to_expire");

    // Asynchronous reset while in E2.
    wr(15'h0555, 8'hAA, 1'b1, S_U1, "rst_c1");
    wr(15'h02AA, 8'h55, 1'b1, S_U2, "rst_c2");
    wr(15'h0555, 8'h80, 1'b1, S_E1, "rst_c3");
    wr(15'h0555, 8'hAA, 1'b1, S_E2, "rst_c4");
    #1;
    reset = 1'b1;
    cpu_addr_in = 15'h02AA;
    cpu_data_in = 8'h55;
    #1;
    exp_rejects = 0;
    check("rst_state", 16'(seq_state), 16'(S_IDLE));
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_allow", 16'(flash_we_allow), 16'h0);
    check("rst_reject", 16'(reject_pulse), 16'h0);
    check("rst_rcount", 16'(reject_count), 16'h0);
    @(negedge m2);
    cpu_rw_in = 1'b1;
    @(negedge m2);
    reset = 1'b0;

    // Disabled: whole program sequence blocked, nothing counted.
    prg_write_enabled = 1'b0;
    wr(15'h0555, 8'hAA, 1'b0, S_IDLE, "dis_c1");
    wr(15'h02AA, 8'h55, 1'b0, S_IDLE, "dis_c2");
    wr(15'h0555, 8'hA0, 1'b0, S_IDLE, "dis_c3");
    wr(15'h1234, 8'h5C, 1'b0, S_IDLE, "dis_data");
    prg_write_enabled = 1'b1;

    // Saturation of the reject counter.
    for (int i = 0; i < 300; i++) wr(15'h0100, 8'h77, 1'b0, S_IDLE, "sat");
    check("sat_final", 16'(reject_count), STATS ? 16'h00FF : 16'h0000);

    check("sb_empty", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
